sincronizador_vga: RTL and testbench
====================================

# sincronizador_vga

Generates the 640x480 @ 60 Hz VGA raster timing: pixel-rate tick, horizontal and vertical pixel counters, active-low sync pulses, and visible-area flag. It is the source of the `Qh`/`Qv` coordinates consumed by the tile/font renderer. Its `hsync`/`vsync` go to the connector after the renderer's colour stage.

## Interface
Parameters:
- `DIV`, 4: `reloj` cycles per pixel (100 MHz -> 25 MHz); must be >= 1.
- `H_VIS`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch.
- `H_SYNC`, 96: horizontal sync width.
- `H_BP`, 48: horizontal back porch.
- `V_VIS`, 480: visible lines.
- `V_FP`, 10: vertical front porch.
- `V_SYNC`, 2: vertical sync width.
- `V_BP`, 33: vertical back porch.

Ports:
- `reloj`, in, 1: system clock. This is the only clock.
- `resetM`, in, 1: reset, asynchronous and active-low.
- `Qh`, out, 10: horizontal pixel counter, 0..H_TOTAL-1.
- `Qv`, out, 10: vertical line counter, 0..V_TOTAL-1.
- `hsync`, out, 1: horizontal sync, active-low.
- `vsync`, out, 1: vertical sync, active-low.
- `video_on`, out, 1: high when inside the visible area.
- `pixel_tick`, out, 1: one-`reloj` strobe marking the last cycle of each pixel.
- `frame_start`, out, 1: one-`reloj` strobe when the raster enters (0,0).

## Operation
- Derived totals: H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP = 800; V_TOTAL = 525.
- Prescaler `div_q` counts 0..DIV-1 and wraps. `pixel_tick` = (`div_q` == DIV-1), decoded from the register.
- Horizontal FSM phases are derived from `Qh`: VISIBLE [0, H_VIS-1], FRONT [640, 655], SYNC [656, 751], BACK [752, 799].
- On a clock edge with `pixel_tick`:
  - `Qh` increments; 799 -> 0 wraps.
  - When `Qh` wraps, `Qv` increments; 524 -> 0 wraps.
- Vertical phases: VISIBLE [0, 479], FRONT [480, 489], SYNC [490, 491], BACK [492, 524].
- `hsync` = 0 exactly when `Qh` is in [656, 751].
- `vsync` = 0 exactly when `Qv` is in [490, 491].
- `video_on` = (`Qh` < 640) && (`Qv` < 480).
- `hsync`, `vsync` and `video_on` are registered, computed from the next counter values, so they change on the same edge as `Qh`/`Qv`. There is zero skew relative to the coordinates.
- `frame_start` is registered. It is high for the single cycle following the edge where (`Qh`,`Qv`) moves from (799,524) to (0,0).
- Counter arithmetic is unsigned 10-bit. Parameters must keep the totals <= 1024, checked by elaboration assertion.
- DIV = 1: `pixel_tick` is constantly 1 and counters advance every cycle.

## Timing
- Reset values while `resetM` = 0:
  - `div_q` = 0, `Qh` = 0, `Qv` = 0.
  - `hsync` = 1, `vsync` = 1, `video_on` = 1.
  - `pixel_tick` = 0 (forced low during reset), `frame_start` = 0.
- Reset assertion takes effect immediately (asynchronous). Release is synchronous to `reloj`: the first count edge is the first rising edge with `resetM` = 1.
- After release, `Qh` = 0 holds for exactly DIV cycles. Every later `Qh` value also holds exactly DIV cycles.
- Line period = 800·DIV = 3200 cycles. Frame period = 420000·DIV = 1,680,000 cycles.
- Mid-frame reset: all outputs return to reset values at once. The next frame restarts from (0,0) with no `frame_start` pulse for that restart. No partial sync pulse may persist.
- Simultaneous wraps: the H wrap, V wrap and `frame_start` all resolve on the same edge.

## Structure
- Package `vga_timing_pkg`: timing constants (visible, porch and sync widths, totals) and the phase enum (VISIBLE, FRONT, SYNC, BACK).
- Sub-module `contador_modulo`: a parameterised mod-N counter with enable input and terminal-count output.
  - Used three times: the prescaler (N = DIV), horizontal (N = H_TOTAL) and vertical (N = V_TOTAL, enabled by the horizontal terminal count ANDed with tick).
- Sync and visible decode sits in the top level.

## Test plan
- Reset release, DIV=4 -> `pixel_tick` high on cycles 3, 7, 11…; `Qh` = 1 at cycle 4; `Qv` = 0; `hsync` = `vsync` = 1.
- Run one line -> `Qh` goes 799 -> 0 and `Qv` goes 0 -> 1 on the same edge, 3200 cycles after release.
- Horizontal window:
  - `hsync` falls on the edge where `Qh` becomes 656 and rises when `Qh` becomes 752 (96 pixels = 384 cycles).
  - `video_on` falls when `Qh` becomes 640.
- Full frame:
  - `vsync` is low exactly while `Qv` is in {490, 491} (1600 pixels).
  - At (799,524) -> (0,0), `frame_start` is a 1-cycle pulse at cycle 1,680,000.
- Assert `resetM` = 0 mid-line at `Qh` = 700, `Qv` = 491:
  - `vsync` = 1 and `Qh` = `Qv` = 0 immediately, with no clock edge needed.
  - After release, the timing is identical to the first scenario.
- DIV=1 build -> `pixel_tick` constant 1; line period 800 cycles; sync windows unchanged in pixel units.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 VGA timing constants and raster phase decode
package vga_timing_pkg;

  localparam int DIV_DEF    = 4;
  localparam int H_VIS_DEF  = 640;
  localparam int H_FP_DEF   = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF   = 48;
  localparam int V_VIS_DEF  = 480;
  localparam int V_FP_DEF   = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF   = 33;

  localparam int H_TOTAL_DEF = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  typedef enum logic [1:0] {
    VISIBLE = 2'd0,
    FRONT   = 2'd1,
    SYNC    = 2'd2,
    BACK    = 2'd3
  } fase_t;

  // Back porch is whatever remains after visible + front + sync.
  function automatic fase_t fase_de(input logic [9:0] pos, input int vis, input int fp,
                                    input int sw);
    int p;
    p = int'({22'd0, pos});
    if (p < vis)                return VISIBLE;
    else if (p < vis + fp)      return FRONT;
    else if (p < vis + fp + sw) return SYNC;
    else                        return BACK;
  endfunction

endpackage

// File: rtl/contador_modulo.sv
// rtl/contador_modulo.sv - mod-N counter with enable, look-ahead next value and terminal count
module contador_modulo #(
  parameter int N = 2,
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] q,
  output logic [W-1:0] q_next,
  output logic         tc
);

  localparam logic [W-1:0] ULTIMO = W'(N - 1);

  assign tc = (q == ULTIMO);

  always_comb begin
    q_next = q;
    if (en) begin
      q_next = tc ? '0 : q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/sincronizador_vga.sv
// rtl/sincronizador_vga.sv - VGA raster timing: pixel tick, H/V counters, syncs, visible flag
module sincronizador_vga
  import vga_timing_pkg::*;
#(
  parameter int DIV    = DIV_DEF,
  parameter int H_VIS  = H_VIS_DEF,
  parameter int H_FP   = H_FP_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BP   = H_BP_DEF,
  parameter int V_VIS  = V_VIS_DEF,
  parameter int V_FP   = V_FP_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BP   = V_BP_DEF
) (
  input  logic       reloj,
  input  logic       resetM,
  output logic [9:0] Qh,
  output logic [9:0] Qv,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       pixel_tick,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 1 || H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_param_check
    $error("sincronizador_vga: DIV must be >= 1 and H/V totals must not exceed 1024");
  end

  logic [DW-1:0] div_q;
  logic [DW-1:0] div_next;
  logic          tick_int;
  logic          unused_div;

  contador_modulo #(.N(DIV), .W(DW)) u_prescaler (
    .clk    (reloj),
    .rst_n  (resetM),
    .en     (1'b1),
    .q      (div_q),
    .q_next (div_next),
    .tc     (tick_int)
  );

  assign unused_div = ^{div_q, div_next};

  logic [9:0] h_next;
  logic [9:0] v_next;
  logic       h_tc;
  logic       v_tc;
  logic       v_en;

  contador_modulo #(.N(H_TOTAL), .W(10)) u_horizontal (
    .clk    (reloj),
    .rst_n  (resetM),
    .en     (tick_int),
    .q      (Qh),
    .q_next (h_next),
    .tc     (h_tc)
  );

  assign v_en = tick_int & h_tc;

  contador_modulo #(.N(V_TOTAL), .W(10)) u_vertical (
    .clk    (reloj),
    .rst_n  (resetM),
    .en     (v_en),
    .q      (Qv),
    .q_next (v_next),
    .tc     (v_tc)
  );

  // Decoding the look-ahead values keeps syncs aligned with the coordinates they belong to.
  fase_t h_fase_d;
  fase_t v_fase_d;

  always_comb begin
    h_fase_d = fase_de(h_next, H_VIS, H_FP, H_SYNC);
    v_fase_d = fase_de(v_next, V_VIS, V_FP, V_SYNC);
  end

  assign pixel_tick = tick_int & resetM;

  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      hsync       <= (h_fase_d != SYNC);
      vsync       <= (v_fase_d != SYNC);
      video_on    <= (h_fase_d == VISIBLE) && (v_fase_d == VISIBLE);
      frame_start <= v_en & v_tc;
    end
  end

endmodule

// File: tb/tb_sincronizador_vga.sv
// tb/tb_sincronizador_vga.sv - raster model comparison for default, DIV=2 and DIV=1 builds
module tb_sincronizador_vga;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] qh_a, qv_a, qh_b, qv_b, qh_c, qv_c;
  logic hs_a, vs_a, von_a, tick_a, fs_a;
  logic hs_b, vs_b, von_b, tick_b, fs_b;
  logic hs_c, vs_c, von_c, tick_c, fs_c;

  sincronizador_vga u_dut_a (
    .reloj(clk), .resetM(rst_n), .Qh(qh_a), .Qv(qv_a), .hsync(hs_a), .vsync(vs_a),
    .video_on(von_a), .pixel_tick(tick_a), .frame_start(fs_a)
  );

  sincronizador_vga #(
    .DIV(2), .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_VIS(6), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_dut_b (
    .reloj(clk), .resetM(rst_n), .Qh(qh_b), .Qv(qv_b), .hsync(hs_b), .vsync(vs_b),
    .video_on(von_b), .pixel_tick(tick_b), .frame_start(fs_b)
  );

  sincronizador_vga #(
    .DIV(1), .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_VIS(6), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_dut_c (
    .reloj(clk), .resetM(rst_n), .Qh(qh_c), .Qv(qv_c), .hsync(hs_c), .vsync(vs_c),
    .video_on(von_c), .pixel_tick(tick_c), .frame_start(fs_c)
  );

  typedef struct {
    int qh;
    int qv;
    int hs;
    int vs;
    int von;
    int tick;
    int fs;
  } vga_t;

  int total = 0;
  int bad = 0;
  int n = 0;
  bit checking = 1'b0;

  // Clock edges seen since the last reset release; everything else follows from it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n <= 0;
    else        n <= n + 1;
  end

  function automatic vga_t modelo(int cyc, int dv, int hv, int hfp, int hsw, int hbp,
                                  int vv, int vfp, int vsw, int vbp, bit en_reset);
    vga_t e;
    int ht, vt, p, x, y;
    ht = hv + hfp + hsw + hbp;
    vt = vv + vfp + vsw + vbp;
    p = cyc / dv;
    x = p % ht;
    y = (p / ht) % vt;
    e.qh = x;
    e.qv = y;
    e.hs = (x >= hv + hfp && x < hv + hfp + hsw) ? 0 : 1;
    e.vs = (y >= vv + vfp && y < vv + vfp + vsw) ? 0 : 1;
    e.von = (x < hv && y < vv) ? 1 : 0;
    e.tick = (!en_reset && (cyc % dv == dv - 1)) ? 1 : 0;
    e.fs = ((cyc % dv == 0) && p > 0 && (p % (ht * vt) == 0)) ? 1 : 0;
    return e;
  endfunction

  task automatic chk(input string nombre, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (n=%0d t=%0t)", nombre, act, req, n, $time);
    end
  endtask

  task automatic cmp_all(input string tag, input vga_t got, input vga_t req);
    chk({tag, ".Qh"}, got.qh, req.qh);
    chk({tag, ".Qv"}, got.qv, req.qv);
    chk({tag, ".hsync"}, got.hs, req.hs);
    chk({tag, ".vsync"}, got.vs, req.vs);
    chk({tag, ".video_on"}, got.von, req.von);
    chk({tag, ".pixel_tick"}, got.tick, req.tick);
    chk({tag, ".frame_start"}, got.fs, req.fs);
  endtask

  always @(negedge clk) begin
    vga_t g;
    if (checking) begin
      g = '{int'(qh_a), int'(qv_a), int'(hs_a), int'(vs_a), int'(von_a), int'(tick_a), int'(fs_a)};
      cmp_all("A", g, modelo(n, 4, 640, 16, 96, 48, 480, 10, 2, 33, !rst_n));
      g = '{int'(qh_b), int'(qv_b), int'(hs_b), int'(vs_b), int'(von_b), int'(tick_b), int'(fs_b)};
      cmp_all("B", g, modelo(n, 2, 16, 2, 4, 3, 6, 2, 2, 3, !rst_n));
      g = '{int'(qh_c), int'(qv_c), int'(hs_c), int'(vs_c), int'(von_c), int'(tick_c), int'(fs_c)};
      cmp_all("C", g, modelo(n, 1, 16, 2, 4, 3, 6, 2, 2, 3, !rst_n));
    end
  end

  initial begin
    bit hit;
    repeat (2) @(negedge clk);
    checking = 1'b1;
    chk("rst.Qh_a", int'(qh_a), 0);
    chk("rst.hsync_a", int'(hs_a), 1);
    chk("rst.video_on_a", int'(von_a), 1);
    chk("rst.tick_c", int'(tick_c), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Run into B's vertical sync, then reset asynchronously between edges.
    hit = 1'b0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      @(negedge clk);
      if (n == 496) hit = 1'b1;
    end
    chk("mid.reach", int'(hit), 1);
    chk("mid.Qh_b", int'(qh_b), 23);
    chk("mid.Qv_b", int'(qv_b), 9);
    chk("mid.vsync_b", int'(vs_b), 0);
    chk("mid.Qh_a", int'(qh_a), 124);
    #2 rst_n = 1'b0;
    #1;
    chk("async.Qh_b", int'(qh_b), 0);
    chk("async.Qv_b", int'(qv_b), 0);
    chk("async.vsync_b", int'(vs_b), 1);
    chk("async.Qh_a", int'(qh_a), 0);
    chk("async.tick_c", int'(tick_c), 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk("rel.tick_c", int'(tick_c), 1);
    chk("rel.frame_start_c", int'(fs_c), 0);

    for (int i = 0; i < 7000; i++) begin
      @(negedge clk);
      if (n == 2)    chk("lit.tick_a@2", int'(tick_a), 0);
      if (n == 3)    chk("lit.tick_a@3", int'(tick_a), 1);
      if (n == 7)    chk("lit.tick_a@7", int'(tick_a), 1);
      if (n == 4)    chk("lit.Qh_a@4", int'(qh_a), 1);
      if (n == 2559) chk("lit.video_on_a@2559", int'(von_a), 1);
      if (n == 2560) chk("lit.video_on_a@2560", int'(von_a), 0);
      if (n == 2623) chk("lit.hsync_a@2623", int'(hs_a), 1);
      if (n == 2624) chk("lit.hsync_a@2624", int'(hs_a), 0);
      if (n == 3007) chk("lit.hsync_a@3007", int'(hs_a), 0);
      if (n == 3008) chk("lit.hsync_a@3008", int'(hs_a), 1);
      if (n == 3199) begin
        chk("lit.Qh_a@3199", int'(qh_a), 799);
        chk("lit.Qv_a@3199", int'(qv_a), 0);
      end
      if (n == 3200) begin
        chk("lit.Qh_a@3200", int'(qh_a), 0);
        chk("lit.Qv_a@3200", int'(qv_a), 1);
      end
      if (n == 399)  chk("lit.vsync_b@399", int'(vs_b), 1);
      if (n == 400)  chk("lit.vsync_b@400", int'(vs_b), 0);
      if (n == 499)  chk("lit.vsync_b@499", int'(vs_b), 0);
      if (n == 500)  chk("lit.vsync_b@500", int'(vs_b), 1);
      if (n == 649) begin
        chk("lit.Qh_b@649", int'(qh_b), 24);
        chk("lit.Qv_b@649", int'(qv_b), 12);
        chk("lit.frame_start_b@649", int'(fs_b), 0);
      end
      if (n == 650) chk("lit.frame_start_b@650", int'(fs_b), 1);
      if (n == 651) chk("lit.frame_start_b@651", int'(fs_b), 0);
      if (n == 17)  chk("lit.hsync_c@17", int'(hs_c), 1);
      if (n == 18)  chk("lit.hsync_c@18", int'(hs_c), 0);
      if (n == 22)  chk("lit.hsync_c@22", int'(hs_c), 1);
      if (n == 25) begin
        chk("lit.Qh_c@25", int'(qh_c), 0);
        chk("lit.Qv_c@25", int'(qv_c), 1);
      end
      if (n == 325) chk("lit.frame_start_c@325", int'(fs_c), 1);
      if (n == 326) chk("lit.tick_c@326", int'(tick_c), 1);
    end

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
